// File: rtl/bus_arbiter_if.sv
// Signal bundle joining the two requesting masters, the arbiter and the downstream slave bus.
// The arbiter connects through the slave modport; the requesters and the slave device use master.
interface bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    // Handshake: a master requests with re=1 or any we bit set and holds request and payload
    // stable until its one-cycle done pulse; the slave completes the presented access in any
    // cycle where bus_ready=1 while bus_* are held, and bus_rdata is valid only in that cycle.
    logic              m0_re;
    logic [BE_W-1:0]   m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_done;
    logic              m0_stall;

    logic              m1_re;
    logic [BE_W-1:0]   m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_done;
    logic              m1_stall;

    logic              bus_re;
    logic [BE_W-1:0]   bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ready;
    logic              bus_err;

    modport slave (
        input  m0_re, m0_we, m0_addr, m0_wdata,
        input  m1_re, m1_we, m1_addr, m1_wdata,
        input  bus_rdata, bus_ready,
        output m0_rdata, m0_done, m0_stall,
        output m1_rdata, m1_done, m1_stall,
        output bus_re, bus_we, bus_addr, bus_wdata, bus_err
    );

    modport master (
        output m0_re, m0_we, m0_addr, m0_wdata,
        output m1_re, m1_we, m1_addr, m1_wdata,
        output bus_rdata, bus_ready,
        input  m0_rdata, m0_done, m0_stall,
        input  m1_rdata, m1_done, m1_stall,
        input  bus_re, bus_we, bus_addr, bus_wdata, bus_err
    );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master / one-slave data-bus arbiter with alternating priority under contention.
// Optional BUS_TIMEOUT_EN aborts a BUSY access after TIMEOUT_CYCLES cycles without bus_ready.
module bus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rst,
    bus_arbiter_if.slave bif,
    output logic [1:0]   dbg_state_o,
    output logic         dbg_prio_o
);
    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              prio_q, prio_d;
    logic              bus_re_q, bus_re_d;
    logic [BE_W-1:0]   bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
    logic              req0, req1;

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
`else
    logic              unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    assign req0 = bif.m0_re | (|bif.m0_we);
    assign req1 = bif.m1_re | (|bif.m1_we);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            prio_q      <= 1'b0;
            bus_re_q    <= 1'b0;
            bus_we_q    <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
`ifdef BUS_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            prio_q      <= prio_d;
            bus_re_q    <= bus_re_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
`ifdef BUS_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        prio_d      = prio_q;
        bus_re_d    = bus_re_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
`ifdef BUS_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    // Under contention prio picks; otherwise the sole requester wins.
                    gnt_d = (req0 & req1) ? prio_q : req1;
                    if (gnt_d) begin
                        bus_re_d    = bif.m1_re & ~(|bif.m1_we);
                        bus_we_d    = bif.m1_we;
                        bus_addr_d  = bif.m1_addr;
                        bus_wdata_d = bif.m1_wdata;
                    end else begin
                        bus_re_d    = bif.m0_re & ~(|bif.m0_we);
                        bus_we_d    = bif.m0_we;
                        bus_addr_d  = bif.m0_addr;
                        bus_wdata_d = bif.m0_wdata;
                    end
`ifdef BUS_TIMEOUT_EN
                    cnt_d = '0;
`endif
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bif.bus_ready) begin
                    if (bus_re_q) begin
                        if (gnt_q) m1_rdata_d = bif.bus_rdata;
                        else       m0_rdata_d = bif.bus_rdata;
                    end
                    bus_re_d = 1'b0;
                    bus_we_d = '0;
                    prio_d   = ~gnt_q;
                    state_d  = RESP;
                end
`ifdef BUS_TIMEOUT_EN
                else if (cnt_q + 1'b1 == CNT_W'(TIMEOUT_CYCLES)) begin
                    if (gnt_q) m1_rdata_d = '0;
                    else       m0_rdata_d = '0;
                    bus_re_d = 1'b0;
                    bus_we_d = '0;
                    prio_d   = ~gnt_q;
                    err_d    = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bif.bus_re    = bus_re_q;
        bif.bus_we    = bus_we_q;
        bif.bus_addr  = bus_addr_q;
        bif.bus_wdata = bus_wdata_q;
        bif.m0_rdata  = m0_rdata_q;
        bif.m1_rdata  = m1_rdata_q;
        bif.m0_done   = (state_q == RESP) && !gnt_q;
        bif.m1_done   = (state_q == RESP) && gnt_q;
        // Stall is held low while rst is asserted so every output reads 0 in reset.
        bif.m0_stall  = req0 && !bif.m0_done && !rst;
        bif.m1_stall  = req1 && !bif.m1_done && !rst;
`ifdef BUS_TIMEOUT_EN
        bif.bus_err   = err_q;
`else
        bif.bus_err   = 1'b0;
`endif
        dbg_state_o   = state_q;
        dbg_prio_o    = prio_q;
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: a responder drives bus_ready/bus_rdata and a monitor
// compares each done pulse against a queue of expected completions. Timeout cases need BUS_TIMEOUT_EN.
module tb_bus_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TO     = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;
    logic       dbg_prio;

    bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

    bus_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bif(bif),
        .dbg_state_o(dbg_state),
        .dbg_prio_o(dbg_prio)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          wait_cycles;
    logic [33:0] exp_q[$];          // {err, master, expected rdata of that master}
    logic [31:0] push_rd[2];
    logic [31:0] seen_rd[2];
    logic [33:0] mon_e;
    logic        mon_mid;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_txn(input logic mid, input logic is_read, input logic [31:0] rd,
                              input logic err);
        if (err)          push_rd[mid] = '0;
        else if (is_read) push_rd[mid] = rd;
        exp_q.push_back({err, mid, push_rd[mid]});
    endtask

    task automatic drive_m(input logic mid, input logic re, input logic [3:0] we,
                           input logic [31:0] addr, input logic [31:0] wd);
        if (mid) begin
            bif.m1_re = re; bif.m1_we = we; bif.m1_addr = addr; bif.m1_wdata = wd;
        end else begin
            bif.m0_re = re; bif.m0_we = we; bif.m0_addr = addr; bif.m0_wdata = wd;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        push_rd[0] = '0; push_rd[1] = '0;
        seen_rd[0] = '0; seen_rd[1] = '0;
        @(negedge clk);
        check("rst_bus", {bif.bus_re, bif.bus_we, bif.bus_addr, bif.bus_wdata}, 0);
        check("rst_rdata", {bif.m0_rdata, bif.m1_rdata}, 0);
        check("rst_flags", {bif.m0_done, bif.m1_done, bif.m0_stall, bif.m1_stall, bif.bus_err}, 0);
        check("rst_state", {dbg_state, dbg_prio}, 0);
        rst = 1'b0;
    endtask

    // Waits for the granted access, checks it, then completes it after delay cycles
    // (delay < 0: never assert bus_ready, wait for the done pulse instead).
    task automatic serve(input int delay, input logic [31:0] rd, input logic [31:0] exp_addr,
                         input logic exp_re, input logic [3:0] exp_we, input logic [31:0] exp_wd);
        int n = 0;
        while (!bif.bus_re && bif.bus_we == 4'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("bus_start", (n < 40), 1);
        check("bus_addr", bif.bus_addr, exp_addr);
        check("bus_re", bif.bus_re, exp_re);
        check("bus_we", bif.bus_we, exp_we);
        check("bus_wdata", bif.bus_wdata, exp_wd);
        if (delay < 0) begin
            n = 0;
            while (!bif.m0_done && !bif.m1_done && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("done_wait", (n < 40), 1);
            wait_cycles = n;
        end else begin
            repeat (delay) begin
                @(negedge clk);
                check("bus_hold", {bif.bus_addr, bif.bus_re, bif.bus_we}, {exp_addr, exp_re, exp_we});
            end
            bif.bus_rdata = rd;
            bif.bus_ready = 1'b1;
            @(negedge clk);
            bif.bus_ready = 1'b0;
            bif.bus_rdata = $urandom;
        end
        check("bus_clr", {bif.bus_re, bif.bus_we}, 0);
    endtask

    always @(negedge clk) begin
        if (!rst && (bif.m0_done || bif.m1_done)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", {bif.m1_done, bif.m0_done}, 0);
            end else begin
                mon_e   = exp_q.pop_front();
                mon_mid = mon_e[32];
                check("done_master", {bif.m1_done, bif.m0_done}, mon_mid ? 2'b10 : 2'b01);
                check("rdata", mon_mid ? bif.m1_rdata : bif.m0_rdata, mon_e[31:0]);
                check("other_rdata", mon_mid ? bif.m0_rdata : bif.m1_rdata, seen_rd[!mon_mid]);
                check("bus_err", bif.bus_err, mon_e[33]);
                check("prio_after", dbg_prio, !mon_mid);
                check("stall_at_done", mon_mid ? bif.m1_stall : bif.m0_stall, 0);
                seen_rd[mon_mid] = mon_e[31:0];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a0, a1, rd;
        logic [3:0]  we;
        int          n;
        drive_m(1'b0, 1'b0, 4'b0, 32'h0, 32'h0);
        drive_m(1'b1, 1'b0, 4'b0, 32'h0, 32'h0);
        bif.bus_ready = 1'b0;
        bif.bus_rdata = '0;
        do_reset();

        // bus_ready with no access in flight is ignored
        bif.bus_ready = 1'b1;
        bif.bus_rdata = 32'hDEAD_BEEF;
        repeat (3) begin
            @(negedge clk);
            check("idle_ready", {dbg_state, bif.m0_done, bif.m1_done}, 0);
        end
        bif.bus_ready = 1'b0;

        // M0 read alone with fixed data, bus_ready two cycles after bus_re
        drive_m(1'b0, 1'b1, 4'b0, 32'h100, 32'h0);
        expect_txn(1'b0, 1'b1, 32'hCAFE0001, 1'b0);
        @(negedge clk);
        check("t1_grant", {bif.bus_re, bif.bus_addr}, {1'b1, 32'h100});
        check("t1_m1_idle", {bif.m1_rdata, bif.m1_done, bif.m1_stall}, 0);
        serve(2, 32'hCAFE0001, 32'h100, 1'b1, 4'b0, 32'h0);
        drive_m(1'b0, 1'b0, 4'b0, 32'h0, 32'h0);
        @(negedge clk);

        // Both masters at once from reset: M0 write first, then M1 read
        do_reset();
        drive_m(1'b0, 1'b0, 4'b1111, 32'h80, 32'h11);
        drive_m(1'b1, 1'b1, 4'b0, 32'h200, 32'h0);
        expect_txn(1'b0, 1'b0, 32'h0, 1'b0);
        rd = $urandom;
        expect_txn(1'b1, 1'b1, rd, 1'b0);
        @(negedge clk);
        check("t2_stalls", {bif.m0_stall, bif.m1_stall}, 2'b11);
        check("t2_first", bif.bus_addr, 32'h80);
        serve(1, $urandom, 32'h80, 1'b0, 4'b1111, 32'h11);
        check("t2_m1_stall", bif.m1_stall, 1);
        drive_m(1'b0, 1'b0, 4'b0, 32'h0, 32'h0);
        serve($urandom_range(0, 2), rd, 32'h200, 1'b1, 4'b0, 32'h0);
        drive_m(1'b1, 1'b0, 4'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("t2_prio", dbg_prio, 0);

        // Continuous contention: grants must alternate 0,1,0,1
        a0 = $urandom_range(32'h1000, 32'h1FFF);
        a1 = $urandom_range(32'h2000, 32'h2FFF);
        drive_m(1'b0, 1'b1, 4'b0, a0, 32'h0);
        drive_m(1'b1, 1'b1, 4'b0, a1, 32'h0);
        for (int k = 0; k < 4; k++) begin
            rd = $urandom;
            expect_txn(k[0], 1'b1, rd, 1'b0);
            serve($urandom_range(0, 2), rd, k[0] ? a1 : a0, 1'b1, 4'b0, 32'h0);
        end
        drive_m(1'b0, 1'b0, 4'b0, 32'h0, 32'h0);
        drive_m(1'b1, 1'b0, 4'b0, 32'h0, 32'h0);
        @(negedge clk);

        // Read and write enables together on M1 are a write; rdata must stay put
        we = 4'b0011;
        a1 = $urandom;
        drive_m(1'b1, 1'b1, we, 32'h300, a1);
        expect_txn(1'b1, 1'b0, 32'h0, 1'b0);
        serve(1, $urandom | 32'h1, 32'h300, 1'b0, we, a1);
        drive_m(1'b1, 1'b0, 4'b0, 32'h0, 32'h0);
        @(negedge clk);

        // Reset during BUSY drops the access; the held request is then served afresh
        drive_m(1'b0, 1'b1, 4'b0, 32'h500, 32'h0);
        expect_txn(1'b0, 1'b1, 32'h5, 1'b0);
        serve(0, 32'h5, 32'h500, 1'b1, 4'b0, 32'h0);
        drive_m(1'b0, 1'b0, 4'b0, 32'h0, 32'h0);
        @(negedge clk);
        drive_m(1'b0, 1'b1, 4'b0, 32'h600, 32'h0);
        n = 0;
        while (!bif.bus_re && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t5_busy", {dbg_state, dbg_prio}, {2'd1, 1'b1});
        do_reset();
        check("t5_no_done", {bif.m0_done, bif.m1_done}, 0);
        rd = $urandom | 32'h1;
        expect_txn(1'b0, 1'b1, rd, 1'b0);
        serve(1, rd, 32'h600, 1'b1, 4'b0, 32'h0);
        drive_m(1'b0, 1'b0, 4'b0, 32'h0, 32'h0);
        @(negedge clk);

`ifdef BUS_TIMEOUT_EN
        // Slave never answers: abort after TO waiting cycles with bus_err and cleared rdata
        drive_m(1'b0, 1'b1, 4'b0, 32'h700, 32'h0);
        expect_txn(1'b0, 1'b1, 32'h0, 1'b1);
        serve(-1, 32'h0, 32'h700, 1'b1, 4'b0, 32'h0);
        check("to_len", wait_cycles, TO);
        drive_m(1'b0, 1'b0, 4'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("to_err_pulse", bif.bus_err, 0);

        // bus_ready in the timeout cycle itself completes normally
        rd = $urandom | 32'h1;
        drive_m(1'b0, 1'b1, 4'b0, 32'h704, 32'h0);
        expect_txn(1'b0, 1'b1, rd, 1'b0);
        serve(TO - 1, rd, 32'h704, 1'b1, 4'b0, 32'h0);
        drive_m(1'b0, 1'b0, 4'b0, 32'h0, 32'h0);
        @(negedge clk);
`endif

        repeat (2) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master, one-slave arbiter for the core's data bus (re / byte-we / addr / wdata / rdata).
- Master 0 is the CPU data port. Master 1 is a secondary requester (debug/DMA).
- Adds a slave-ready handshake and per-master done/stall signals.
- Sits between cpu_core's memory-access bus and the peripheral/memory bus decoder.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- TIMEOUT_CYCLES, 255, bus_ready wait limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m0_re  in  1  master 0 read request
- m0_we  in  DATA_W/8  master 0 byte write enables
- m0_addr  in  ADDR_W  master 0 address
- m0_wdata  in  DATA_W  master 0 write data
- m0_rdata  out  DATA_W  master 0 read data, registered
- m0_done  out  1  master 0 transaction complete, 1-cycle pulse
- m0_stall  out  1  master 0 request pending and not yet done
- m1_re, m1_we, m1_addr, m1_wdata, m1_rdata, m1_done, m1_stall  same as m0_*, for master 1
- bus_re  out  1  slave read strobe, registered
- bus_we  out  DATA_W/8  slave byte write enables, registered
- bus_addr  out  ADDR_W  slave address, registered
- bus_wdata  out  DATA_W  slave write data, registered
- bus_rdata  in  DATA_W  slave read data, valid when bus_ready=1
- bus_ready  in  1  slave accepts/completes current access
- bus_err  out  1  timeout abort pulse; tied 0 without the optional feature

Behaviour:
- Reset (rst=1 at a clk edge):
  - FSM goes to IDLE and prio=0.
  - All outputs become 0: bus_*, m*_rdata, m*_done, m*_stall, bus_err.
  - An in-flight transaction is dropped with no done pulse.
- Request detection: a master requests when mX_re=1 or mX_we!=0.
- Re and we together: the access is a write; bus_re is driven 0.
- Master rule: hold request and payload stable until mX_done; request may be dropped or changed in the cycle after done.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One master requesting: grant it.
  - Both requesting: grant the master indexed by prio.
  - On grant: latch the granted master's re/we/addr/wdata into the bus_* registers, set gnt, go to BUSY.
- BUSY:
  - bus_* outputs are held constant.
  - On bus_ready=1: if the access is a read, capture bus_rdata into m<gnt>_rdata; if a write, m<gnt>_rdata is unchanged. Then clear bus_re/bus_we to 0, set prio = ~gnt, go to RESP.
- RESP: m<gnt>_done=1 for exactly this cycle, then go to IDLE.
  - Requests are first re-sampled in the following IDLE cycle. A still-asserted request counts as a new transaction.
- Latency:
  - Request seen in IDLE at cycle 0.
  - bus_* valid at cycle 1.
  - bus_ready earliest at cycle 1.
  - done at the cycle after bus_ready.
  - Minimum 3 cycles per transaction, so back-to-back throughput is 1 transaction per 3 cycles.
- Stall: mX_stall = request(X) AND NOT (RESP and gnt==X). Combinational from inputs and state.
- Non-granted master: stall stays 1 throughout; its rdata is untouched.
- Fairness: prio only changes on completion, so alternating grants are guaranteed under continuous contention.
- bus_ready in IDLE or RESP is ignored.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - 8-bit-or-wider wait counter, cleared on entry to BUSY, increments each BUSY cycle with bus_ready=0.
  - When the counter reaches TIMEOUT_CYCLES with bus_ready still 0: abort. Clear bus_re/bus_we, set m<gnt>_rdata=0, pulse bus_err in the RESP cycle together with done, set prio=~gnt, go to RESP.
  - bus_ready=1 in the same cycle as timeout wins: normal completion, no error.
- Not defined: no counter; BUSY waits indefinitely; bus_err is constant 0.

Test Plan:
- M0 read alone, addr=0x100, bus_ready asserted 2 cycles after bus_re with bus_rdata=0xCAFE0001 -> bus_re=1, bus_addr=0x100 from cycle 1; m0_rdata=0xCAFE0001 and m0_done=1 one cycle after bus_ready; m1 outputs remain 0.
- Both masters request at once from reset, M0 write we=4'b1111 wdata=0x11, M1 read addr=0x200 -> M0 served first (prio=0); M1 served next with m1_stall=1 until its done; prio ends at 0.
- Continuous contention over 4 transactions -> grant order 0,1,0,1; no back-to-back grant to the same master.
- M1 with m1_re=1 and m1_we=4'b0011 together -> bus_we=4'b0011, bus_re=0; m1_rdata unchanged after done.
- rst=1 while in BUSY -> next edge: bus_*=0, no done pulse, prio=0; a request after reset is granted normally.
- With BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, bus_ready held 0 -> bus_err=1 and m0_done=1 together, m0_rdata=0; bus_ready=1 exactly at the timeout cycle -> normal completion, bus_err=0.
